// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and load/store requests onto one 1-cycle registered-read memory port.
module mem_port_arbiter #(
   parameter int DEPTH = 4096,
   parameter bit LS_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [15:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_data_in,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_data_out
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [16:0] LIM = 17'(DEPTH);
   state_t state, state_n;
   logic last_ls, cur_ls, cur_rd, cur_err;
   logic pick, rd, oor, any;
   logic [15:0] addr;
   // load/store wins ties under priority mode, or when fetch was granted last
   assign any  = if_req | ls_req;
   assign pick = ls_req & (~if_req | LS_PRIO | ~last_ls);
   assign addr = pick ? ls_addr : if_addr;
   assign rd   = pick ? ~ls_we : 1'b1;
   assign oor  = {1'b0, addr} >= LIM;
   always_comb begin
      state_n = state;
      if (state == IDLE) state_n = any ? ACCESS : IDLE;
      else if (state == ACCESS) state_n = RESP;
      else state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_gnt      <= 1'b0;
         if_rvalid   <= 1'b0;
         if_rdata    <= '0;
         if_err      <= 1'b0;
         ls_gnt      <= 1'b0;
         ls_rvalid   <= 1'b0;
         ls_rdata    <= '0;
         ls_err      <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         last_ls     <= 1'b0;
         cur_ls      <= 1'b0;
         cur_rd      <= 1'b0;
         cur_err     <= 1'b0;
      end else begin
         if_gnt    <= 1'b0;
         ls_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         if_err    <= 1'b0;
         ls_err    <= 1'b0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         if (state == IDLE && any) begin
            mem_addr    <= addr;
            mem_data_in <= (pick & ls_we) ? ls_wdata : 32'h0;
            mem_we      <= pick & ls_we & ~oor;
            mem_re      <= rd & ~oor;
            if_gnt      <= ~pick;
            ls_gnt      <= pick;
            last_ls     <= pick;
            cur_ls      <= pick;
            cur_rd      <= rd;
            cur_err     <= oor;
         end
         // read data is on mem_data_out during RESP; out-of-range reads return zero
         if (state == RESP) begin
            ls_rvalid <= cur_ls;
            if_rvalid <= ~cur_ls;
            ls_err    <= cur_ls & cur_err;
            if_err    <= ~cur_ls & cur_err;
            if (cur_rd & cur_ls) ls_rdata <= cur_err ? 32'h0 : mem_data_out;
            if (cur_rd & ~cur_ls) if_rdata <= cur_err ? 32'h0 : mem_data_out;
         end
      end
   end
endmodule
